// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dm_arb_pkg;

    localparam int unsigned MEM_BYTES_DEF = 128;
    localparam int unsigned NREQ = 2;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        gnt_idx;
    } req_t;

    // A word access is legal when aligned and the whole word fits inside memory.
    function automatic logic word_addr_legal(input logic [31:0] addr,
                                             input logic [31:0] mem_bytes);
        return ((addr & WORD_ALIGN_MASK) == 32'd0) && (addr <= (mem_bytes - 32'd4));
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Request/response and memory-side signal bundle of the data-memory arbiter.
interface dm_arbiter_if;
    import dm_arb_pkg::*;

    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ-1:0]    req_ready_o;
    logic [NREQ-1:0]    req_we_i;
    logic [NREQ*32-1:0] req_addr_i;
    logic [NREQ*32-1:0] req_wdata_i;
    logic [NREQ-1:0]    rsp_valid_o;
    logic [31:0]        rsp_rdata_o;
    logic               rsp_err_o;
    logic [31:0]        mem_addr_o;
    logic [31:0]        mem_data_o;
    logic               mem_read_o;
    logic               mem_write_o;
    logic [31:0]        mem_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, mem_data_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output mem_addr_o, mem_data_o, mem_read_o, mem_write_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, mem_data_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  mem_addr_o, mem_data_o, mem_read_o, mem_write_o
    );

endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; prio names the winner on a tie.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    always_comb begin
        gnt_idx = 1'b0;
        if (valid == 2'b11) begin
            gnt_idx = prio;
        end else if (valid[1]) begin
            gnt_idx = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_onehot
            assign gnt[gi] = (valid != 2'b00) && (gnt_idx == 1'(gi));
        end
    endgenerate

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter and one-word-at-a-time sequencer in front of the data memory.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dm_arbiter_if.slave   bus
);

    state_t            state_reg;
    state_t            state_next;
    logic              prio_reg;
    req_t              req_reg;
    logic [31:0]       rdata_reg;
    logic              err_reg;

    logic [31:0]       addr_arr  [NREQ];
    logic [31:0]       wdata_arr [NREQ];
    logic [NREQ-1:0]   arb_gnt;
    logic              arb_idx;
    logic              handshake;
    logic [31:0]       sel_addr;
    logic              sel_legal;

    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_data;
    logic              mem_read;
    logic              mem_write;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_addr_i[gi*32 +: 32];
            assign wdata_arr[gi] = bus.req_wdata_i[gi*32 +: 32];
        end
    endgenerate

    rr_arb2 u_rr_arb2 (
        .valid   (bus.req_valid_i),
        .prio    (prio_reg),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign sel_addr  = addr_arr[arb_idx];
    // Judged on the value being latched, so the FSM can branch on the accept edge.
    assign sel_legal = word_addr_legal(sel_addr, 32'(MEM_BYTES));
    assign handshake = (state_reg == IDLE) && (bus.req_valid_i != '0) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (handshake) begin
                    state_next = sel_legal ? ACCESS : RESP;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_reg  <= 1'b0;
            req_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else if (handshake) begin
            prio_reg      <= ~arb_idx;
            req_reg.we    <= bus.req_we_i[arb_idx];
            req_reg.addr  <= sel_addr;
            req_reg.wdata <= wdata_arr[arb_idx];
            req_reg.gnt_idx <= arb_idx;
            rdata_reg     <= '0;
            err_reg       <= ~sel_legal;
        end else if ((state_reg == ACCESS) && !req_reg.we) begin
            rdata_reg <= bus.mem_data_i;
        end
    end

    // Strobes, ready and the response pulse are all masked while reset is held.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = arb_gnt & {NREQ{~rst_i}};
            end
            ACCESS: begin
                mem_addr  = req_reg.addr;
                mem_read  = ~req_reg.we & ~rst_i;
                mem_write = req_reg.we & ~rst_i;
                mem_data  = req_reg.we ? req_reg.wdata : 32'd0;
            end
            RESP: begin
                rsp_valid[req_reg.gnt_idx] = ~rst_i;
                rsp_rdata = rdata_reg;
                rsp_err   = err_reg;
            end
            default: begin
                req_ready = '0;
            end
        endcase
    end

    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_rdata_o = rsp_rdata;
    assign bus.rsp_err_o   = rsp_err;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_data_o  = mem_data;
    assign bus.mem_read_o  = mem_read;
    assign bus.mem_write_o = mem_write;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a 128-byte little-endian memory model.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   cnt0 = 0;
    int   cnt1 = 0;

    logic [7:0]  mem [128];
    logic        mem_clear;
    logic [31:0] bad_addr [3];
    logic [1:0]  exp_g;

    always #5 clk = ~clk;

    dm_arbiter_if bus ();

    dm_arbiter #(.MEM_BYTES(128)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
        end else if (bus.mem_write_o && (bus.mem_addr_o <= 32'd124)) begin
            for (int b = 0; b < 4; b++) mem[int'(bus.mem_addr_o) + b] <= bus.mem_data_o[8*b +: 8];
        end
    end

    always_comb begin
        bus.mem_data_i = 32'd0;
        if (bus.mem_addr_o <= 32'd124) begin
            bus.mem_data_i = {mem[int'(bus.mem_addr_o) + 3], mem[int'(bus.mem_addr_o) + 2],
                              mem[int'(bus.mem_addr_o) + 1], mem[int'(bus.mem_addr_o)]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid_i[n] = 1'b1;
        bus.req_we_i[n] = we;
        bus.req_addr_i[32*n +: 32] = addr;
        bus.req_wdata_i[32*n +: 32] = wdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_clear = 1'b1;
        bus.req_valid_i = '0;
        bus.req_we_i = '0;
        bus.req_addr_i = '0;
        bus.req_wdata_i = '0;
        bad_addr[0] = 32'h13;
        bad_addr[1] = 32'h7E;
        bad_addr[2] = 32'h80;
        set_req(0, 1'b1, 32'h10, 32'h55);
        tick();
        tick();
        #1;
        chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write_o), 32'd0);
        chk("rst_mem_read", 32'(bus.mem_read_o), 32'd0);
        chk("rst_rdata", bus.rsp_rdata_o, 32'd0);
        chk("rst_err", 32'(bus.rsp_err_o), 32'd0);
        bus.req_valid_i = '0;
        mem_clear = 1'b0;
        rst = 1'b0;
        tick();

        // CPU write 0xDEADBEEF to 0x10
        set_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
        #1;
        chk("wr_ready", 32'(bus.req_ready_o), 32'd1);
        tick();
        bus.req_valid_i[0] = 1'b0;
        #1;
        chk("wr_strobe", 32'(bus.mem_write_o), 32'd1);
        chk("wr_read_low", 32'(bus.mem_read_o), 32'd0);
        chk("wr_addr", bus.mem_addr_o, 32'h10);
        chk("wr_data", bus.mem_data_o, 32'hDEADBEEF);
        chk("wr_no_rsp_yet", 32'(bus.rsp_valid_o), 32'd0);
        tick();
        #1;
        chk("wr_rsp", 32'(bus.rsp_valid_o), 32'd1);
        chk("wr_err", 32'(bus.rsp_err_o), 32'd0);
        chk("wr_rdata", bus.rsp_rdata_o, 32'd0);
        chk("wr_byte10", 32'(mem[16]), 32'hEF);
        chk("wr_byte11", 32'(mem[17]), 32'hBE);
        chk("wr_byte12", 32'(mem[18]), 32'hAD);
        chk("wr_byte13", 32'(mem[19]), 32'hDE);
        $display("txn cpu write addr=0x10 data=0xdeadbeef");
        tick();

        // Loader reads it back
        set_req(1, 1'b0, 32'h10, 32'd0);
        #1;
        chk("rd_ready", 32'(bus.req_ready_o), 32'd2);
        tick();
        bus.req_valid_i[1] = 1'b0;
        #1;
        chk("rd_strobe", 32'(bus.mem_read_o), 32'd1);
        chk("rd_addr", bus.mem_addr_o, 32'h10);
        tick();
        #1;
        chk("rd_rsp", 32'(bus.rsp_valid_o), 32'd2);
        chk("rd_rdata", bus.rsp_rdata_o, 32'hDEADBEEF);
        chk("rd_err", 32'(bus.rsp_err_o), 32'd0);
        $display("txn loader read addr=0x10 data=0x%08h", bus.rsp_rdata_o);
        tick();

        // Both requesters continuously valid
        set_req(0, 1'b0, 32'h10, 32'd0);
        set_req(1, 1'b0, 32'h14, 32'd0);
        for (int k = 0; k < 6; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            chk("rr_ready", 32'(bus.req_ready_o), 32'(exp_g));
            tick();
            tick();
            #1;
            chk("rr_rsp", 32'(bus.rsp_valid_o), 32'(exp_g));
            chk("rr_rdata", bus.rsp_rdata_o, (exp_g == 2'b01) ? 32'hDEADBEEF : 32'd0);
            if (bus.rsp_valid_o[0]) cnt0++;
            if (bus.rsp_valid_o[1]) cnt1++;
            $display("txn rr step=%0d rsp_valid=%b", k, bus.rsp_valid_o);
            tick();
        end
        chk("rr_cnt0", 32'(cnt0), 32'd3);
        chk("rr_cnt1", 32'(cnt1), 32'd3);
        bus.req_valid_i = '0;

        // Illegal addresses: misaligned, straddling end, past end
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b0, bad_addr[k], 32'd0);
            #1;
            chk("ill_ready", 32'(bus.req_ready_o), 32'd1);
            chk("ill_read_t0", 32'(bus.mem_read_o), 32'd0);
            tick();
            bus.req_valid_i[0] = 1'b0;
            #1;
            chk("ill_rsp", 32'(bus.rsp_valid_o), 32'd1);
            chk("ill_err", 32'(bus.rsp_err_o), 32'd1);
            chk("ill_rdata", bus.rsp_rdata_o, 32'd0);
            chk("ill_read", 32'(bus.mem_read_o), 32'd0);
            chk("ill_write", 32'(bus.mem_write_o), 32'd0);
            $display("txn cpu illegal read addr=0x%08h err=%0b", bad_addr[k], bus.rsp_err_o);
            tick();
        end

        // Highest legal word: loader writes, CPU reads
        set_req(1, 1'b1, 32'h7C, 32'hA5A50F0F);
        #1;
        chk("top_wr_ready", 32'(bus.req_ready_o), 32'd2);
        tick();
        bus.req_valid_i[1] = 1'b0;
        #1;
        chk("top_wr_strobe", 32'(bus.mem_write_o), 32'd1);
        tick();
        #1;
        chk("top_wr_rsp", 32'(bus.rsp_valid_o), 32'd2);
        chk("top_wr_err", 32'(bus.rsp_err_o), 32'd0);
        $display("txn loader write addr=0x7c data=0xa5a50f0f");
        tick();
        set_req(0, 1'b0, 32'h7C, 32'd0);
        #1;
        chk("top_rd_ready", 32'(bus.req_ready_o), 32'd1);
        tick();
        bus.req_valid_i[0] = 1'b0;
        #1;
        chk("top_rd_strobe", 32'(bus.mem_read_o), 32'd1);
        tick();
        #1;
        chk("top_rd_rsp", 32'(bus.rsp_valid_o), 32'd1);
        chk("top_rd_rdata", bus.rsp_rdata_o, 32'hA5A50F0F);
        chk("top_rd_err", 32'(bus.rsp_err_o), 32'd0);
        $display("txn cpu read addr=0x7c data=0x%08h", bus.rsp_rdata_o);
        tick();

        // Reset during the ACCESS cycle of a write
        set_req(0, 1'b1, 32'h20, 32'h12345678);
        #1;
        chk("rsta_ready", 32'(bus.req_ready_o), 32'd1);
        tick();
        bus.req_valid_i[0] = 1'b0;
        rst = 1'b1;
        #1;
        chk("rsta_write_gated", 32'(bus.mem_write_o), 32'd0);
        chk("rsta_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rsta_no_rsp_after", 32'(bus.rsp_valid_o), 32'd0);
        chk("rsta_word20", {mem[35], mem[34], mem[33], mem[32]}, 32'd0);
        set_req(0, 1'b0, 32'h20, 32'd0);
        set_req(1, 1'b0, 32'h10, 32'd0);
        #1;
        chk("rsta_prio0_ready", 32'(bus.req_ready_o), 32'd1);
        tick();
        bus.req_valid_i = '0;
        tick();
        #1;
        chk("rsta_rsp", 32'(bus.rsp_valid_o), 32'd1);
        chk("rsta_rdata", bus.rsp_rdata_o, 32'd0);
        $display("txn cpu read addr=0x20 after reset data=0x%08h", bus.rsp_rdata_o);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
